// File: rtl/rx_packet_ctrl_if.sv
// Bit-stream inputs and framed-byte outputs of the USB RX packet sequencer.
interface rx_packet_ctrl_if;
    logic       start_detect;
    logic       shift_enable;
    logic       decoded_bit;
    logic       ignore_bit;
    logic       eop;
    logic       receiving;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic [3:0] rx_pid;
    logic [6:0] byte_count;
    logic       packet_done;
    logic       rx_error;

    modport master (
        output start_detect, shift_enable, decoded_bit, ignore_bit, eop,
        input  receiving, rx_data, byte_valid, rx_pid, byte_count,
        input  packet_done, rx_error
    );

    modport slave (
        input  start_detect, shift_enable, decoded_bit, ignore_bit, eop,
        output receiving, rx_data, byte_valid, rx_pid, byte_count,
        output packet_done, rx_error
    );
endinterface

// File: rtl/rx_packet_ctrl.sv
// USB RX packet sequencer: frames SYNC/PID/DATA bytes and flags errors.
// Define RX_PID_CHECK_EN to reject PIDs whose upper nibble is not ~lower.
module rx_packet_ctrl #(
    parameter int unsigned MAX_BYTES = 64,
    parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
    input  logic            clk,
    input  logic            rst,
    rx_packet_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, SYNC, PID, DATA, DONE, ERROR
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       err_eop;
    logic       bit_ok;
    logic       byte_done;
    logic       pid_ok;
    logic [7:0] next_byte;

    assign bit_ok    = bus.shift_enable & ~bus.ignore_bit & ~bus.eop;
    assign next_byte = {bus.decoded_bit, shreg[7:1]};
    assign byte_done = bit_ok & (bit_cnt == 3'd7);

`ifdef RX_PID_CHECK_EN
    assign pid_ok = (next_byte[7:4] == ~next_byte[3:0]);
`else
    assign pid_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            err_eop         <= 1'b0;
            bus.receiving   <= 1'b0;
            bus.rx_data     <= '0;
            bus.byte_valid  <= 1'b0;
            bus.rx_pid      <= '0;
            bus.byte_count  <= '0;
            bus.packet_done <= 1'b0;
            bus.rx_error    <= 1'b0;
        end else begin
            bus.byte_valid  <= 1'b0;
            bus.packet_done <= 1'b0;
            if (bit_ok) begin
                shreg   <= next_byte;
                bit_cnt <= bit_cnt + 3'd1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.start_detect) begin
                        state          <= SYNC;
                        bit_cnt        <= '0;
                        bus.byte_count <= '0;
                        bus.rx_error   <= 1'b0;
                        bus.receiving  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (bus.eop) begin
                        state        <= ERROR;
                        bus.rx_error <= 1'b1;
                        err_eop      <= 1'b1;
                    end else if (byte_done) begin
                        if (next_byte == SYNC_BYTE) begin
                            state <= PID;
                        end else begin
                            state        <= ERROR;
                            bus.rx_error <= 1'b1;
                        end
                    end
                end
                PID: begin
                    if (bus.eop) begin
                        state        <= ERROR;
                        bus.rx_error <= 1'b1;
                        err_eop      <= 1'b1;
                    end else if (byte_done) begin
                        if (pid_ok) begin
                            state      <= DATA;
                            bus.rx_pid <= next_byte[3:0];
                        end else begin
                            state        <= ERROR;
                            bus.rx_error <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.eop) begin
                        if (bit_cnt == 3'd0) begin
                            state           <= DONE;
                            bus.packet_done <= 1'b1;
                        end else begin
                            state        <= ERROR;
                            bus.rx_error <= 1'b1;
                            err_eop      <= 1'b1;
                        end
                    end else if (byte_done) begin
                        // a full packet keeps its count; the extra byte is dropped
                        if (bus.byte_count == MAX_CNT) begin
                            state        <= ERROR;
                            bus.rx_error <= 1'b1;
                        end else begin
                            bus.rx_data    <= next_byte;
                            bus.byte_valid <= 1'b1;
                            bus.byte_count <= bus.byte_count + 7'd1;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.receiving <= 1'b0;
                end
                ERROR: begin
                    if (bus.eop || err_eop) begin
                        state         <= IDLE;
                        bus.receiving <= 1'b0;
                        err_eop       <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.receiving <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Randomized bench for rx_packet_ctrl against a bit-count packet model.
module tb_rx_packet_ctrl;
    localparam int         MAXB = 4;
    localparam logic [7:0] SYNC = 8'h80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_packet_ctrl_if bus();

    rx_packet_ctrl #(.MAX_BYTES(MAXB), .SYNC_BYTE(SYNC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mode_t;
    mode_t      mode      = M_IDLE;
    int         nbits     = 0;
    logic [7:0] acc       = '0;
    bit         exit_next = 1'b0;
    bit         e_recv    = 1'b0;
    logic [7:0] e_data    = '0;
    bit         e_bv      = 1'b0;
    logic [3:0] e_pid     = '0;
    int         e_cnt     = 0;
    bit         e_pd      = 1'b0;
    bit         e_err     = 1'b0;

    logic [7:0] got_bytes[$];
    int         pd_cnt = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit pid_good();
`ifdef RX_PID_CHECK_EN
        return acc[7:4] == ~acc[3:0];
`else
        return 1'b1;
`endif
    endfunction

    task automatic fail_pkt(bit by_eop);
        mode      = M_ERR;
        e_err     = 1'b1;
        exit_next = by_eop;
    endtask

    // Expected outputs after the next edge, from packet position in valid bits
    task automatic mstep();
        e_bv = 1'b0;
        e_pd = 1'b0;
        if (rst) begin
            mode = M_IDLE; nbits = 0; acc = '0; exit_next = 1'b0;
            e_recv = 1'b0; e_data = '0; e_pid = '0; e_cnt = 0; e_err = 1'b0;
            return;
        end
        case (mode)
            M_IDLE: if (bus.start_detect) begin
                mode = M_RUN; nbits = 0; e_cnt = 0; e_err = 1'b0; e_recv = 1'b1;
            end
            M_DONE: begin
                mode = M_IDLE; e_recv = 1'b0;
            end
            M_ERR: if (bus.eop || exit_next) begin
                mode = M_IDLE; e_recv = 1'b0; exit_next = 1'b0;
            end
            M_RUN: begin
                if (bus.eop) begin
                    if (nbits >= 16 && nbits % 8 == 0) begin
                        mode = M_DONE; e_pd = 1'b1;
                    end else fail_pkt(1'b1);
                end else if (bus.shift_enable && !bus.ignore_bit) begin
                    acc = {bus.decoded_bit, acc[7:1]};
                    nbits++;
                    if (nbits == 8) begin
                        if (acc != SYNC) fail_pkt(1'b0);
                    end else if (nbits == 16) begin
                        if (pid_good()) e_pid = acc[3:0];
                        else fail_pkt(1'b0);
                    end else if (nbits % 8 == 0) begin
                        if (e_cnt == MAXB) fail_pkt(1'b0);
                        else begin
                            e_data = acc; e_bv = 1'b1; e_cnt++;
                        end
                    end
                end
            end
            default: mode = M_IDLE;
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("receiving", 32'(bus.receiving), 32'(e_recv));
            check("rx_data", 32'(bus.rx_data), 32'(e_data));
            check("byte_valid", 32'(bus.byte_valid), 32'(e_bv));
            check("rx_pid", 32'(bus.rx_pid), 32'(e_pid));
            check("byte_count", 32'(bus.byte_count), 32'(e_cnt));
            check("packet_done", 32'(bus.packet_done), 32'(e_pd));
            check("rx_error", 32'(bus.rx_error), 32'(e_err));
            if (bus.byte_valid) got_bytes.push_back(bus.rx_data);
            if (bus.packet_done) pd_cnt++;
            mstep();
        end
    end

    bit rnd_sd = 1'b0;

    task automatic cyc(bit sd, bit se, bit db, bit ib, bit ep);
        bus.start_detect = sd;
        bus.shift_enable = se;
        bus.decoded_bit  = db;
        bus.ignore_bit   = ib;
        bus.eop          = ep;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic bitx(bit b);
        bit sd;
        sd = rnd_sd && ($urandom_range(0, 7) == 0);
        cyc(sd, 1'b1, b, 1'b0, 1'b0);
        idle($urandom_range(0, 2));
    endtask

    task automatic stuff();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic byte_tx(logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (rnd_sd && $urandom_range(0, 15) == 0) stuff();
            bitx(v[i]);
        end
    endtask

    task automatic start();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eop_tx(bit se);
        cyc(1'b0, se, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic clr_log();
        got_bytes.delete();
        pd_cnt = 0;
    endtask

    initial begin
        logic [7:0] ff;
        logic [3:0] v;
        logic [7:0] pidb;
        int nb;
        ff = 8'hFF;
        bus.start_detect = 1'b0;
        bus.shift_enable = 1'b0;
        bus.decoded_bit  = 1'b0;
        bus.ignore_bit   = 1'b0;
        bus.eop          = 1'b0;
        rst = 1'b1;
        idle(2);
        check("reset_recv", 32'(bus.receiving), 32'd0);
        check("reset_cnt", 32'(bus.byte_count), 32'd0);
        rst = 1'b0;
        idle(2);

        // clean packet
        clr_log();
        start();
        byte_tx(SYNC); byte_tx(8'hC3); byte_tx(8'h12); byte_tx(8'h34);
        eop_tx(1'b0);
        check("t1_nbytes", 32'(got_bytes.size()), 32'd2);
        if (got_bytes.size() == 2) begin
            check("t1_b0", 32'(got_bytes[0]), 32'h12);
            check("t1_b1", 32'(got_bytes[1]), 32'h34);
        end
        check("t1_pid", 32'(bus.rx_pid), 32'h3);
        check("t1_cnt", 32'(bus.byte_count), 32'd2);
        check("t1_done", 32'(pd_cnt), 32'd1);
        check("t1_err", 32'(bus.rx_error), 32'd0);

        // stuffed bit inside 0xFF
        clr_log();
        start();
        byte_tx(SYNC); byte_tx(8'hC3);
        for (int i = 0; i < 6; i++) bitx(ff[i]);
        stuff();
        bitx(1'b1); bitx(1'b1);
        eop_tx(1'b1);
        check("t2_nbytes", 32'(got_bytes.size()), 32'd1);
        if (got_bytes.size() == 1) check("t2_b0", 32'(got_bytes[0]), 32'hFF);
        check("t2_done", 32'(pd_cnt), 32'd1);

        // bad SYNC
        clr_log();
        start();
        byte_tx(8'h81);
        check("t3_err", 32'(bus.rx_error), 32'd1);
        byte_tx(8'h12);
        check("t3_nbytes", 32'(got_bytes.size()), 32'd0);
        eop_tx(1'b0);
        check("t3_idle", 32'(bus.receiving), 32'd0);
        check("t3_sticky", 32'(bus.rx_error), 32'd1);
        start();
        check("t3_clear", 32'(bus.rx_error), 32'd0);
        eop_tx(1'b0);

        // partial byte
        clr_log();
        start();
        byte_tx(SYNC); byte_tx(8'hC3); byte_tx(8'h55);
        bitx(1'b1); bitx(1'b0); bitx(1'b1);
        eop_tx(1'b0);
        check("t4_err", 32'(bus.rx_error), 32'd1);
        check("t4_done", 32'(pd_cnt), 32'd0);
        check("t4_cnt", 32'(bus.byte_count), 32'd1);

        // PID with bad complement
        clr_log();
        start();
        byte_tx(SYNC); byte_tx(8'hC4); byte_tx(8'hA5);
        eop_tx(1'b0);
`ifdef RX_PID_CHECK_EN
        check("t5_err", 32'(bus.rx_error), 32'd1);
        check("t5_nbytes", 32'(got_bytes.size()), 32'd0);
`else
        check("t5_pid", 32'(bus.rx_pid), 32'h4);
        check("t5_nbytes", 32'(got_bytes.size()), 32'd1);
        check("t5_done", 32'(pd_cnt), 32'd1);
`endif

        // overflow
        clr_log();
        start();
        byte_tx(SYNC); byte_tx(8'hC3);
        for (int i = 1; i <= MAXB + 1; i++) byte_tx(8'(i));
        check("t6_nbytes", 32'(got_bytes.size()), 32'(MAXB));
        check("t6_err", 32'(bus.rx_error), 32'd1);
        check("t6_cnt", 32'(bus.byte_count), 32'(MAXB));
        eop_tx(1'b0);

        // reset mid-DATA
        start();
        byte_tx(SYNC); byte_tx(8'hC3); byte_tx(8'h77);
        bitx(1'b1); bitx(1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("t7_recv", 32'(bus.receiving), 32'd0);
        check("t7_cnt", 32'(bus.byte_count), 32'd0);
        check("t7_pid", 32'(bus.rx_pid), 32'd0);
        check("t7_data", 32'(bus.rx_data), 32'd0);
        check("t7_bv", 32'(bus.byte_valid), 32'd0);
        idle(2);

        // randomized packets
        rnd_sd = 1'b1;
        for (int p = 0; p < 120; p++) begin
            nb = $urandom_range(0, MAXB + 2);
            start();
            byte_tx($urandom_range(0, 9) == 0 ? 8'($urandom) : SYNC);
            v = 4'($urandom);
            pidb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {~v, v};
            byte_tx(pidb);
            for (int i = 0; i < nb; i++) byte_tx(8'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                int k = $urandom_range(1, 7);
                for (int i = 0; i < k; i++) bitx(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b0;
            end
            eop_tx(1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
